rootmod_child_scheduler: RTL and testbench

- Round-robin scheduler that grants exclusive use of one shared resource to the five child instances of a root module (inst_0..inst_4).
- Sits in the parent module beside the children.
- Each child raises a request, holds ownership until it signals done, then gives up the grant.
- A watchdog reclaims the grant if a child never signals done.

---
 rtl/rootmod_sched_pkg.sv | 27 ++
 rtl/rootmod_child_scheduler_rr_pick.sv | 30 +++
 rtl/rootmod_child_scheduler.sv | 104 ++++++++++
 tb/tb_rootmod_child_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rootmod_sched_pkg.sv
// Shared types and helpers for root-level child schedulers.
// Combinational helpers only; no state lives here.
package rootmod_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } sched_state_e;

  localparam int DEF_NUM_REQ = 5;
  localparam int DEF_ID_W    = 3;

  // Widest vector onehot_to_bin accepts; callers zero-extend into it.
  localparam int MAX_REQ  = 32;
  localparam int MAX_ID_W = 5;

  function automatic logic [MAX_ID_W-1:0] onehot_to_bin(input logic [MAX_REQ-1:0] onehot);
    logic [MAX_ID_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) bin |= MAX_ID_W'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/rootmod_child_scheduler_rr_pick.sv
// Rotating priority encoder: first set req bit at or after ptr, wrapping.
// Purely combinational; ptr must be below NUM_REQ.
module rr_pick
#(
  parameter int NUM_REQ = 5,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    // Walk from the farthest offset down so the nearest hit overrides.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        found = 1'b1;
        idx   = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/rootmod_child_scheduler.sv
// Round-robin owner arbitration for the root's child instances, with a watchdog.
// req in IDLE -> grant next cycle; release costs one turnaround cycle plus one IDLE cycle.
module rootmod_child_scheduler
  import rootmod_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

  sched_state_e      state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [TO_W-1:0]   cnt_q;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              owner_done;
  logic              wd_hit;
  logic [ID_W-1:0]   ptr_next;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_done = done[grant_id];
  assign wd_hit     = (cnt_q == TO_LAST);
  assign ptr_next   = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q     <= GRANT;
            grant       <= NUM_REQ'(1) << pick_idx;
            grant_id    <= pick_idx;
            grant_valid <= 1'b1;
            busy        <= 1'b1;
            cnt_q       <= '0;
          end
        end
        GRANT: begin
          // A done arriving on the watchdog's last cycle still counts as a clean exit.
          if (owner_done || wd_hit) begin
            state_q     <= RELEASE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr_q       <= ptr_next;
            timeout_err <= ~owner_done;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  a_onehot:     assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_valid:      assert property (@(posedge clk) disable iff (rst) grant_valid == (|grant));
  a_id_match:   assert property (@(posedge clk) disable iff (rst) grant[grant_id] == grant_valid);
  a_id_bin:     assert property (@(posedge clk) disable iff (rst)
                  grant_valid |-> grant_id == ID_W'(onehot_to_bin(MAX_REQ'(grant))));
  a_busy:       assert property (@(posedge clk) disable iff (rst) !busy |-> grant == '0);
  a_err_pulse:  assert property (@(posedge clk) disable iff (rst) timeout_err |=> !timeout_err);

endmodule

// File: tb/tb_rootmod_child_scheduler.sv
// Scoreboarded bench for rootmod_child_scheduler (watchdog shortened to 4 cycles).
module tb_rootmod_child_scheduler;

  localparam int NUM_REQ = 5;
  localparam int ID_W    = 3;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic               timeout_err;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic prev_valid = 1'b0;
  logic prev_terr  = 1'b0;

  rootmod_child_scheduler #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each new grant is matched against the next expected owner.
  always @(negedge clk) begin
    int e;
    check("inv_onehot0", 32'($onehot0(grant)), 1);
    check("inv_valid", grant_valid, |grant);
    if (!busy) check("inv_idle_nogrant", grant, 0);
    if (prev_terr) check("inv_terr_pulse", timeout_err, 0);
    if (grant_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_grant", grant_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_grant_id", grant_id, e);
        check("sb_grant", grant, 32'(1) << e);
        check("sb_busy", busy, 1);
      end
    end
    prev_valid <= grant_valid;
    prev_terr  <= timeout_err;
  end

  task automatic wait_grant(output int gap);
    bit seen;
    seen = 1'b0;
    gap  = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      done = '0;
      if (grant_valid) seen = 1'b1;
      else gap++;
    end
    if (!seen) check("wait_grant", grant_valid, 1);
  endtask

  task automatic release_after(input int k, input int id);
    repeat (k) @(negedge clk);
    check("hold_valid", grant_valid, 1);
    done = NUM_REQ'(1) << id;
  endtask

  task automatic settle();
    @(negedge clk);
    done = '0;
    @(negedge clk);
  endtask

  initial begin
    int gap;
    int held;
    int rr_ids[6] = '{0, 1, 2, 3, 4, 0};

    rst  = 1'b1;
    req  = '0;
    done = '0;
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_valid", grant_valid, 0);
    check("rst_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
    rst = 1'b0;

    // Single request, released by done.
    req = 5'b00100;
    exp_q.push_back(2);
    wait_grant(gap);
    check("t1_latency", gap, 0);
    check("t1_grant", grant, 5'b00100);
    check("t1_id", grant_id, 2);
    check("t1_busy", busy, 1);
    req  = '0;
    done = 5'b00100;
    @(negedge clk);
    done = '0;
    check("t1_rel_grant", grant, 0);
    check("t1_rel_valid", grant_valid, 0);
    check("t1_rel_busy", busy, 1);
    check("t1_rel_terr", timeout_err, 0);
    @(negedge clk);
    check("t1_idle_busy", busy, 0);

    // Reset brings the pointer back to 0 for the round-robin run.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    req = '1;
    foreach (rr_ids[k]) exp_q.push_back(rr_ids[k]);
    foreach (rr_ids[k]) begin
      wait_grant(gap);
      check("rr_gap", gap, (k == 0) ? 0 : 2);
      release_after(2, rr_ids[k]);
    end
    req = '0;
    settle();

    // Pointer is 1: serve 3, then 0 must beat 3 on wrap-around.
    req = 5'b01000;
    exp_q.push_back(3);
    wait_grant(gap);
    req = 5'b01001;
    exp_q.push_back(0);
    release_after(1, 3);
    settle();
    wait_grant(gap);
    check("wrap_id", grant_id, 0);
    req = '0;
    release_after(1, 0);
    settle();

    // Watchdog revokes an owner that never finishes.
    req = 5'b00010;
    exp_q.push_back(1);
    wait_grant(gap);
    req  = '0;
    held = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!grant_valid) break;
      held++;
    end
    check("wd_held", held, TIMEOUT);
    check("wd_terr", timeout_err, 1);
    check("wd_grant", grant, 0);
    check("wd_busy", busy, 1);
    @(negedge clk);
    check("wd_terr_drop", timeout_err, 0);
    check("wd_idle_busy", busy, 0);

    // Pointer must now be 2, so 2 wins over 1.
    req = 5'b00110;
    exp_q.push_back(2);
    wait_grant(gap);
    check("wd_ptr_id", grant_id, 2);
    req = '0;
    release_after(0, 2);
    settle();

    // Foreign done is ignored; owner done on the last watchdog cycle wins.
    req = 5'b00010;
    exp_q.push_back(1);
    wait_grant(gap);
    req = '0;
    @(negedge clk);
    done = 5'b01000;
    @(negedge clk);
    done = '0;
    check("ign_grant", grant, 5'b00010);
    check("ign_id", grant_id, 1);
    @(negedge clk);
    done = 5'b00010;
    @(negedge clk);
    done = '0;
    check("sim_grant", grant, 0);
    check("sim_terr", timeout_err, 0);
    check("sim_busy", busy, 1);
    @(negedge clk);

    // Reset while id 4 owns; pointer must restart at 0.
    req = 5'b10000;
    exp_q.push_back(4);
    wait_grant(gap);
    check("mid_grant", grant, 5'b10000);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_valid", grant_valid, 0);
    check("mid_rst_id", grant_id, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_terr", timeout_err, 0);
    rst = 1'b0;
    req = 5'b10001;
    exp_q.push_back(0);
    wait_grant(gap);
    check("mid_after_id", grant_id, 0);
    req = '0;
    release_after(0, 0);
    settle();

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
